i2c_slave_rx: RTL and testbench
===============================

Name: i2c_slave_rx

Overview:
- I2C slave (target) block that consumes the SDA/SCL bus produced by the team's I2C master.
- Oversamples SCL/SDA with the system clock, detects START and STOP, matches a 7-bit address and ACKs it.
- Delivers received write bytes to local logic with a valid pulse; serves read bytes on request.
- Used as the bus-side endpoint in loopback benches and as the register-access front end of on-chip peripherals.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this slave responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in; legal values 2..3.

Ports:
- clk  in  1  system clock; must be at least 8x SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_in  in  1  bus SCL level (asynchronous).
- sda_in  in  1  bus SDA level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- rx_data  out  8  last received write byte, MSB first on bus.
- rx_valid  out  1  one-clk pulse when rx_data updates.
- tx_data  in  8  byte to return on a read; sampled on tx_req.
- tx_req  out  1  one-clk pulse requesting the next read byte.
- start_det  out  1  one-clk pulse on START or repeated START.
- stop_det  out  1  one-clk pulse on STOP.
- busy  out  1  high from an address match until STOP, or until a START that is not matched.

Behaviour:
- Reset (async, rst_n=0):
  - sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, start_det=0, stop_det=0, busy=0.
  - State IDLE; synchronizers preset to 1 (idle bus).
  - Reset mid-transfer releases SDA immediately.
- Sampling:
  - scl_in/sda_in pass through SYNC_STAGES flops, then one history flop.
  - scl_rise/scl_fall/sda_rise/sda_fall are single-clk edge strobes.
- Condition detection:
  - START = sda_fall while synced SCL=1.
  - STOP = sda_rise while synced SCL=1.
  - Both override any state: START -> ADDR with bit count cleared; STOP -> IDLE.
  - Both release sda_oe in the same clk.
- Bit rules:
  - Data is sampled on scl_rise.
  - sda_oe changes only on scl_fall, except on a START/STOP override.
  - Shift register is 8 bits, MSB first; 3-bit bit counter.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 addr + R/W).
    - On the 8th scl_rise: match -> ADDR_ACK with busy=1; mismatch -> IDLE with busy=0 (ignore bus until next START).
  - ADDR_ACK:
    - sda_oe=1 from the 8th-bit scl_fall to the following scl_fall.
    - If R/W=1: tx_req pulses on the scl_rise of the ACK bit, and tx_data is latched in the same clk.
    - Then RX (R/W=0) or TX (R/W=1).
  - RX:
    - Shift 8 bits. On the 8th scl_rise, rx_data <= shifted byte and rx_valid pulses the next clk.
    - -> RX_ACK.
  - RX_ACK: always ACK (sda_oe=1 for the ACK bit period), then -> RX.
  - TX:
    - On each scl_fall, sda_oe = ~tx_bit, MSB first (the first bit is driven at the ACK-ending scl_fall).
    - After the 8th bit's scl_fall, release -> TX_ACK.
  - TX_ACK: sample master ACK on scl_rise.
    - ACK (SDA=0): tx_req pulse, latch tx_data, -> TX.
    - NACK: -> IDLE_WAIT with SDA released, busy held.
  - IDLE_WAIT: wait for STOP or START.
- Simultaneous events:
  - STOP/START take priority over bit processing in the same clk.
  - start_det/stop_det pulse even when the address does not match.
- Boundaries:
  - A STOP in the middle of a byte discards the partial byte, with no rx_valid.
  - A repeated START after a write switches direction without STOP.
  - A 0-byte write (address then STOP) gives no rx_valid.
  - The slave never stretches SCL.

Decomposition:
- Package i2c_pkg: state encoding localparams (IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IDLE_WAIT), and ACK=1'b0 / NACK=1'b1.
- Sub-module i2c_sync_edge: synchronizer plus edge strobes, instantiated once per bus line.
- Core FSM and shift logic stay in i2c_slave_rx.

Test Plan:
- Write 0x50+W, bytes 0xA5, 0x3C, STOP
  - Expect start_det 1 pulse and three ACK low periods.
  - Expect rx_valid twice with rx_data 0xA5 then 0x3C, then stop_det and busy=0.
- Write to 0x51 (mismatch), byte 0xFF
  - Expect sda_oe never asserted, no rx_valid, busy=0, start_det and stop_det still pulse.
- Read 0x50+R with tx_data 0x96 then 0x0F; master ACKs the first byte and NACKs the second
  - Expect tx_req twice and bus bits 10010110, 00001111.
  - Expect SDA released after the NACK and IDLE after STOP.
- Write 0x50+W, 0x11, repeated START, 0x50+R
  - Expect rx_valid(0x11), a second start_det, tx_req, and correct read byte without an intervening stop_det.
- STOP after 4 data bits of a write
  - Expect no rx_valid, stop_det pulse, busy=0.
- rst_n low during the ACK of 0x50+W
  - Expect sda_oe=0 in the same cycle, all outputs at reset values, and the next transaction received normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and ACK levels for the I2C slave
package i2c_pkg;
   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IDLE_WAIT
   } state_t;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - bus line synchronizer with single-clk rise/fall strobes
module i2c_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync;
   logic              hist;

   // Preset high so an idle bus produces no edge when reset is released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '1;
         hist <= 1'b1;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         hist <= sync[STAGES-1];
      end
   end

   assign level = sync[STAGES-1];
   assign rise  = level & ~hist;
   assign fall  = ~level & hist;
endmodule

// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - I2C target: START/STOP detect, address match, write receive, read serve
module i2c_slave_rx
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       start_det,
   output logic       stop_det,
   output logic       busy
);
   logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
   logic start_c, stop_c;

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
      .clk(clk), .rst_n(rst_n), .din(scl_in), .level(scl), .rise(scl_rise), .fall(scl_fall));
   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
      .clk(clk), .rst_n(rst_n), .din(sda_in), .level(sda), .rise(sda_rise), .fall(sda_fall));

   assign start_c = sda_fall & scl;
   assign stop_c  = sda_rise & scl;

   state_t     state, state_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [7:0] shift, shift_n, tx_shift, tx_shift_n, rx_data_n;
   logic       rw, rw_n, tx_last, tx_last_n;
   logic       sda_oe_n, rx_valid_n, tx_req_n, start_n, stop_n, busy_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shift     <= 8'h00;
         tx_shift  <= 8'h00;
         rw        <= 1'b0;
         tx_last   <= 1'b0;
         sda_oe    <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         tx_shift  <= tx_shift_n;
         rw        <= rw_n;
         tx_last   <= tx_last_n;
         sda_oe    <= sda_oe_n;
         rx_data   <= rx_data_n;
         rx_valid  <= rx_valid_n;
         tx_req    <= tx_req_n;
         start_det <= start_n;
         stop_det  <= stop_n;
         busy      <= busy_n;
      end
   end

   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      shift_n    = shift;
      tx_shift_n = tx_shift;
      rw_n       = rw;
      tx_last_n  = tx_last;
      sda_oe_n   = sda_oe;
      rx_data_n  = rx_data;
      rx_valid_n = 1'b0;
      tx_req_n   = 1'b0;
      start_n    = 1'b0;
      stop_n     = 1'b0;
      busy_n     = busy;
      // Bus conditions preempt whatever bit the FSM was handling
      if (start_c) begin
         start_n   = 1'b1;
         state_n   = ADDR;
         bit_cnt_n = 3'd0;
         sda_oe_n  = 1'b0;
      end else if (stop_c) begin
         stop_n   = 1'b1;
         state_n  = IDLE;
         sda_oe_n = 1'b0;
         busy_n   = 1'b0;
      end else begin
         case (state)
            ADDR: if (scl_rise) begin
               shift_n   = {shift[6:0], sda};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (shift[6:0] == SLAVE_ADDR) begin
                     state_n = ADDR_ACK;
                     busy_n  = 1'b1;
                     rw_n    = sda;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_rise && rw && sda_oe) begin
                  tx_req_n   = 1'b1;
                  tx_shift_n = tx_data;
               end
               // First fall starts the ACK, second fall ends it
               if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe_n = 1'b1;
                  end else if (rw) begin
                     sda_oe_n   = ~tx_shift[7];
                     tx_shift_n = {tx_shift[6:0], 1'b0};
                     bit_cnt_n  = 3'd1;
                     tx_last_n  = 1'b0;
                     state_n    = TX;
                  end else begin
                     sda_oe_n  = 1'b0;
                     bit_cnt_n = 3'd0;
                     state_n   = RX;
                  end
               end
            end
            RX: if (scl_rise) begin
               shift_n   = {shift[6:0], sda};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rx_data_n  = {shift[6:0], sda};
                  rx_valid_n = 1'b1;
                  state_n    = RX_ACK;
               end
            end
            RX_ACK: if (scl_fall) begin
               if (!sda_oe) begin
                  sda_oe_n = 1'b1;
               end else begin
                  sda_oe_n  = 1'b0;
                  bit_cnt_n = 3'd0;
                  state_n   = RX;
               end
            end
            TX: if (scl_fall) begin
               if (tx_last) begin
                  sda_oe_n = 1'b0;
                  state_n  = TX_ACK;
               end else begin
                  sda_oe_n   = ~tx_shift[7];
                  tx_shift_n = {tx_shift[6:0], 1'b0};
                  bit_cnt_n  = bit_cnt + 3'd1;
                  tx_last_n  = (bit_cnt == 3'd7);
               end
            end
            TX_ACK: if (scl_rise) begin
               if (sda == NACK) begin
                  state_n = IDLE_WAIT;
               end else begin
                  tx_req_n   = 1'b1;
                  tx_shift_n = tx_data;
                  bit_cnt_n  = 3'd0;
                  tx_last_n  = 1'b0;
                  state_n    = TX;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - directed bench driving an I2C master model against i2c_slave_rx
module tb_i2c_slave_rx;
   localparam int Q = 50;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl_m, sda_m;
   logic       sda_oe, rx_valid, tx_req, start_det, stop_det, busy;
   logic [7:0] rx_data, tx_data;
   logic       scl_in, sda_in;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
      .start_det(start_det), .stop_det(stop_det), .busy(busy));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_start = 0, n_stop = 0, n_rxv = 0, n_txreq = 0, n_oe = 0, n_busy = 0;
   logic [7:0] rx_log [8];

   always @(negedge clk) begin
      if (start_det) n_start <= n_start + 1;
      if (stop_det)  n_stop  <= n_stop + 1;
      if (tx_req)    n_txreq <= n_txreq + 1;
      if (sda_oe)    n_oe    <= n_oe + 1;
      if (busy)      n_busy  <= n_busy + 1;
      if (rx_valid) begin
         rx_log[n_rxv % 8] <= rx_data;
         n_rxv <= n_rxv + 1;
      end
   end

   task automatic bus_start;
      sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic bus_rstart;
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop;
      sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
   endtask

   task automatic clk_bit(input logic b, output logic r);
      sda_m = b; #Q; scl_m = 1'b1; #Q; r = sda_in; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
      clk_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, r);
         d[i] = r;
      end
      clk_bit(mack, r);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
      #2;
      total++;
      if ({sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy} !== 14'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy});
      end
      #50; rst_n = 1'b1; #100;
   endtask

   task automatic test_write;
      int s0, p0, v0;
      logic a0, a1, a2;
      s0 = n_start; p0 = n_stop; v0 = n_rxv;
      bus_start;
      write_byte(8'hA0, a0);
      write_byte(8'hA5, a1);
      write_byte(8'h3C, a2);
      total++;
      if ({a0, a1, a2} !== 3'b000) begin
         bad++; $display("FAIL write_acks got=%b exp=000", {a0, a1, a2});
      end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL write_busy got=%b exp=1", busy); end
      bus_stop;
      total++;
      if (n_start - s0 != 1) begin bad++; $display("FAIL write_start got=%0d exp=1", n_start - s0); end
      total++;
      if (n_rxv - v0 != 2) begin bad++; $display("FAIL write_rxv got=%0d exp=2", n_rxv - v0); end
      total++;
      if (rx_log[v0 % 8] !== 8'hA5 || rx_log[(v0 + 1) % 8] !== 8'h3C) begin
         bad++;
         $display("FAIL write_data got=%h,%h exp=a5,3c", rx_log[v0 % 8], rx_log[(v0 + 1) % 8]);
      end
      total++;
      if (n_stop - p0 != 1 || busy !== 1'b0) begin
         bad++; $display("FAIL write_stop got=%0d/%b exp=1/0", n_stop - p0, busy);
      end
   endtask

   task automatic test_mismatch;
      int s0, p0, v0, o0, b0;
      logic a0, a1;
      s0 = n_start; p0 = n_stop; v0 = n_rxv; o0 = n_oe; b0 = n_busy;
      bus_start;
      write_byte(8'hA2, a0);
      write_byte(8'hFF, a1);
      bus_stop;
      total++;
      if ({a0, a1} !== 2'b11 || n_oe != o0) begin
         bad++; $display("FAIL mis_sda got=%b/%0d exp=11/0", {a0, a1}, n_oe - o0);
      end
      total++;
      if (n_rxv != v0 || n_busy != b0) begin
         bad++; $display("FAIL mis_rx_busy got=%0d/%0d exp=0/0", n_rxv - v0, n_busy - b0);
      end
      total++;
      if (n_start - s0 != 1 || n_stop - p0 != 1) begin
         bad++; $display("FAIL mis_det got=%0d/%0d exp=1/1", n_start - s0, n_stop - p0);
      end
   endtask

   task automatic test_read;
      int t0;
      logic a;
      logic [7:0] d1, d2;
      t0 = n_txreq;
      tx_data = 8'h96;
      bus_start;
      write_byte(8'hA1, a);
      tx_data = 8'h0F;
      read_byte(1'b0, d1);
      read_byte(1'b1, d2);
      total++;
      if (a !== 1'b0 || d1 !== 8'h96 || d2 !== 8'h0F) begin
         bad++; $display("FAIL read_data got=%b/%h/%h exp=0/96/0f", a, d1, d2);
      end
      total++;
      if (n_txreq - t0 != 2) begin bad++; $display("FAIL read_txreq got=%0d exp=2", n_txreq - t0); end
      total++;
      if (sda_oe !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL read_nack got=%b/%b exp=0/1", sda_oe, busy);
      end
      bus_stop;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL read_stop_busy got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back;
      int s0, p0, v0, t0;
      logic a0, a1, a2;
      logic [7:0] d;
      s0 = n_start; p0 = n_stop; v0 = n_rxv; t0 = n_txreq;
      tx_data = 8'hC3;
      bus_start;
      write_byte(8'hA0, a0);
      write_byte(8'h11, a1);
      bus_rstart;
      write_byte(8'hA1, a2);
      read_byte(1'b1, d);
      total++;
      if ({a0, a1, a2} !== 3'b000 || d !== 8'hC3) begin
         bad++; $display("FAIL rs_read got=%b/%h exp=000/c3", {a0, a1, a2}, d);
      end
      total++;
      if (n_rxv - v0 != 1 || rx_log[v0 % 8] !== 8'h11) begin
         bad++; $display("FAIL rs_rx got=%0d/%h exp=1/11", n_rxv - v0, rx_log[v0 % 8]);
      end
      total++;
      if (n_start - s0 != 2 || n_stop != p0 || n_txreq - t0 != 1) begin
         bad++;
         $display("FAIL rs_det got=%0d/%0d/%0d exp=2/0/1", n_start - s0, n_stop - p0, n_txreq - t0);
      end
      bus_stop;
   endtask

   task automatic test_partial_stop;
      int p0, v0;
      logic a, r;
      p0 = n_stop; v0 = n_rxv;
      bus_start;
      write_byte(8'hA0, a);
      clk_bit(1'b1, r); clk_bit(1'b0, r); clk_bit(1'b1, r); clk_bit(1'b1, r);
      bus_stop;
      total++;
      if (n_rxv != v0 || n_stop - p0 != 1 || busy !== 1'b0) begin
         bad++; $display("FAIL partial got=%0d/%0d/%b exp=0/1/0", n_rxv - v0, n_stop - p0, busy);
      end
   endtask

   task automatic test_reset_mid;
      int v0;
      logic a, r;
      bus_start;
      for (int i = 7; i >= 0; i--) clk_bit(i == 5 || i == 7 ? 1'b1 : 1'b0, r);
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
      total++;
      if (sda_oe !== 1'b1) begin bad++; $display("FAIL rstmid_ack got=%b exp=1", sda_oe); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy} !== 14'h0) begin
         bad++;
         $display("FAIL rstmid_outputs got=%h exp=0",
                  {sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy});
      end
      #49; rst_n = 1'b1; #100;
      v0 = n_rxv;
      bus_start;
      write_byte(8'hA0, a);
      write_byte(8'h5A, r);
      bus_stop;
      total++;
      if ({a, r} !== 2'b00 || n_rxv - v0 != 1 || rx_log[v0 % 8] !== 8'h5A) begin
         bad++;
         $display("FAIL rstmid_after got=%b/%0d/%h exp=00/1/5a", {a, r}, n_rxv - v0, rx_log[v0 % 8]);
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_mismatch;
      test_read;
      test_back_to_back;
      test_partial_stop;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
